spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 flash responder: the target end of the SoC's single-bit boot-flash interface (CEN/SCLK/MOSI/MISO).
- Used in FPGA bring-up and co-simulation as a boot ROM that answers the SoC's flash reads.
- Oversamples the SPI pins on the system clock, decodes READ (0x03) and JEDEC ID (0x9F), and fetches data bytes from a byte-wide memory port.

Parameters:
- ADDR_W, 24, memory address width; the address counter wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4018, 3-byte ID returned by 0x9F, MSB first.

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_cen  input  1  chip enable, active low, asynchronous to clk.
- spi_sclk  input  1  SPI clock, asynchronous to clk.
- spi_mosi  input  1  controller-to-responder data.
- spi_miso  output  1  responder-to-controller data.
- mem_rd  output  1  one-cycle read request strobe.
- mem_addr  output  ADDR_W  read address, valid while mem_rd is high.
- mem_rdata  input  8  read data, valid with mem_ready.
- mem_ready  input  1  read data valid; at most 2 clk after mem_rd.
- busy  output  1  high while CEN is low (synchronized).
- underrun  output  1  sticky flag; cleared only by reset.

Behaviour:
- Reset: clk and a single asynchronous active-low reset rst_n. While rst_n is low all state clears immediately:
  - FSM = IDLE, spi_miso = 1, mem_rd = 0, mem_addr = 0, busy = 0, underrun = 0.
- Input synchronization: cen, sclk and mosi each pass through 2 flops. Edge detection uses the synced sclk plus one delay flop.
  - Rise: sample MOSI. Fall: shift MISO.
  - Detect latency is 3 clk from the pin edge.
- Synced CEN high forces IDLE and spi_miso = 1 from any state. This aborts any partial byte or pending fetch; a late mem_ready is ignored.
- Synced CEN falling edge: IDLE -> CMD with bit counter = 0.
- CMD: shift 8 bits MSB-first on rises. After the 8th rise:
  - 0x03 -> ADDR.
  - 0x9F -> ID, with the shift register loaded from JEDEC_ID[23:16].
  - Any other value -> IGNORE.
- ADDR: shift 24 bits MSB-first. The low ADDR_W bits form the address; upper bits are discarded.
  - On the clk after the 24th rise: mem_rd = 1 for one clk with mem_addr = address -> DATA.
- DATA:
  - A one-byte buffer captures mem_rdata when mem_ready is high.
  - At each byte boundary (the first fall of the byte), the shift register loads from the buffer and drives bit 7 on MISO.
  - Bits 6..0 are driven on the following falls.
  - In the clk after each buffer-to-shift load: address += 1 (wrap at 2^ADDR_W), then issue mem_rd for the new address.
  - If the buffer is not valid at a load: load 0xFF and set underrun.
  - Data streams until CEN rises.
- ID:
  - Shift out the JEDEC_ID bytes MSB-first on falls.
  - After 24 bits, MISO = 0 until CEN rises. No memory access.
- IGNORE: spi_miso = 1, no memory access, exit only on CEN high.
- MISO first-bit timing: bit 7 of the first data byte is driven after the fall that follows the 24th address rise.
  - At 8x oversampling that leaves at least 4 clk for the fetch, which the 2-cycle mem_ready bound satisfies.
- Simultaneous events:
  - CEN rise coinciding with an SCLK edge: CEN wins, the edge is dropped.
  - mem_ready in the same clk as a buffer load: the load takes the old buffer state, then the buffer captures the new data.
- busy = synced CEN inverted, registered.

Test Plan:
- Memory holding mem[i] = i[7:0]; CEN low, send 0x03, 0x000010, clock 32 data bits -> MISO bytes 0x10, 0x11, 0x12, 0x13; mem_rd pulses at addresses 0x10..0x14; underrun = 0.
- Send 0x9F, clock 32 bits -> 0xEF, 0x40, 0x18, 0x00; mem_rd never asserted.
- ADDR_W = 24, read from 0xFFFFFE for 4 bytes -> 0xFE, 0xFF, 0x00, 0x01; mem_addr wraps to 0.
- Unknown command 0x05 plus 16 clocks -> MISO stays 1, no mem_rd. Then CEN high and a new 0x03 at 0x000000 -> returns 0x00, 0x01 correctly.
- CEN rises mid-byte (bit 4 of byte 2) during READ -> spi_miso = 1 within 3 clk, FSM idle. The next READ at 0x000020 starts cleanly with 0x20.
- mem_ready held off 6 clk at 8x SCLK -> first byte 0xFF, underrun = 1 and it stays set after CEN high. rst_n pulse mid-transaction -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 boot-flash responder: oversamples CEN/SCLK/MOSI on clk, answers READ (0x03)
// from a byte-wide memory port and JEDEC ID (0x9F) from a parameter.
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cen,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StId, StIgnore} state_e;

    localparam logic [ADDR_W-1:0] AddrOne = 1;

    logic              cen_s1_q, cen_s2_q, cen_dly_q;
    logic              sclk_s1_q, sclk_s2_q, sclk_dly_q;
    logic              mosi_s1_q, mosi_s2_q;
    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       in_sr_q, in_sr_d;
    logic [7:0]        out_sr_q, out_sr_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic              inc_q, inc_d;
    logic              miso_q, miso_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              sclk_rise, sclk_fall;
    logic [7:0]        load_byte;

    assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s2_q & sclk_dly_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        inc_d      = 1'b0;
        miso_d     = miso_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        busy_d     = ~cen_s2_q;
        underrun_d = underrun_q;
        load_byte  = out_sr_q;

        // CEN high outranks any SCLK edge detected in the same cycle.
        if (cen_s2_q) begin
            state_d   = StIdle;
            miso_d    = 1'b1;
            buf_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cen_dly_q) begin
                        state_d   = StCmd;
                        bit_cnt_d = 5'd0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        in_sr_d   = {in_sr_q[22:0], mosi_s2_q};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (in_sr_d[7:0] == 8'h03) begin
                                state_d = StAddr;
                            end else if (in_sr_d[7:0] == 8'h9F) begin
                                state_d  = StId;
                                out_sr_d = JEDEC_ID[23:16];
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        in_sr_d   = {in_sr_q[22:0], mosi_s2_q};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            state_d    = StData;
                            bit_cnt_d  = 5'd0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = in_sr_d[ADDR_W-1:0];
                        end
                    end
                end
                StData: begin
                    if (inc_q) begin
                        mem_addr_d = mem_addr_q + AddrOne;
                        mem_rd_d   = 1'b1;
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            load_byte  = buf_vld_q ? buf_q : 8'hFF;
                            underrun_d = underrun_q | ~buf_vld_q;
                            buf_vld_d  = 1'b0;
                            inc_d      = 1'b1;
                        end
                        miso_d    = load_byte[7];
                        out_sr_d  = {load_byte[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    // Capture after the load so a same-cycle load sees the old buffer.
                    if (mem_ready) begin
                        buf_d     = mem_rdata;
                        buf_vld_d = 1'b1;
                    end
                end
                StId: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q < 5'd24) begin
                            miso_d    = out_sr_q[7];
                            out_sr_d  = {out_sr_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            if (bit_cnt_q[2:0] == 3'd7) begin
                                unique case (bit_cnt_q[4:3])
                                    2'd0:    out_sr_d = JEDEC_ID[15:8];
                                    2'd1:    out_sr_d = JEDEC_ID[7:0];
                                    default: out_sr_d = 8'h00;
                                endcase
                            end
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                end
                StIgnore: begin
                    miso_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_s1_q   <= 1'b1;
            cen_s2_q   <= 1'b1;
            cen_dly_q  <= 1'b1;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_dly_q <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= StIdle;
            bit_cnt_q  <= 5'd0;
            in_sr_q    <= 24'd0;
            out_sr_q   <= 8'd0;
            buf_q      <= 8'd0;
            buf_vld_q  <= 1'b0;
            inc_q      <= 1'b0;
            miso_q     <= 1'b1;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cen_s1_q   <= spi_cen;
            cen_s2_q   <= cen_s1_q;
            cen_dly_q  <= cen_s2_q;
            sclk_s1_q  <= spi_sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_dly_q <= sclk_s2_q;
            mosi_s1_q  <= spi_mosi;
            mosi_s2_q  <= mosi_s1_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            in_sr_q    <= in_sr_d;
            out_sr_q   <= out_sr_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            inc_q      <= inc_d;
            miso_q     <= miso_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign spi_miso = miso_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: an SPI controller task drives transactions, a memory model answers
// fetches, and expected bytes/addresses come from the flash's address arithmetic.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 24;
    localparam logic [23:0] Jedec  = 24'hEF4018;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              spi_cen, spi_sclk, spi_mosi, spi_miso;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              busy, underrun;

    int n_checks = 0;
    int n_errors = 0;

    int              mem_lat = 1;
    int              rdy_cnt = 0;
    logic [23:0]     pend_addr = 24'd0;
    logic [23:0]     rd_log[$];

    spi_flash_responder #(
        .ADDR_W  (ADDR_W),
        .JEDEC_ID(Jedec)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cen  (spi_cen),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Flash content model: byte at address a is a[7:0]; response after mem_lat clk.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rdy_cnt > 0) begin
            rdy_cnt = rdy_cnt - 1;
            if (rdy_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = pend_addr[7:0];
            end
        end
        if (mem_rd === 1'b1) begin
            rd_log.push_back(mem_addr);
            pend_addr = mem_addr;
            if (mem_lat <= 1) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr[7:0];
            end else begin
                rdy_cnt = mem_lat - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: fall + drive MOSI, half period, rise + sample MISO, half period (8x oversampling).
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[i];
            wait_clk(4);
            spi_sclk = 1'b1;
            rx[i]    = spi_miso;
            wait_clk(4);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic start_txn();
        rd_log.delete();
        spi_cen = 1'b0;
        wait_clk(4);
    endtask

    task automatic end_txn();
        wait_clk(4);
        spi_cen = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b0;
        wait_clk(8);
    endtask

    task automatic send_read_hdr(input logic [23:0] addr);
        logic [7:0] rx;
        spi_byte(8'h03, rx);
        spi_byte(addr[23:16], rx);
        spi_byte(addr[15:8], rx);
        spi_byte(addr[7:0], rx);
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes, input int lat);
        logic [7:0]  rx;
        logic [23:0] a;
        mem_lat = lat;
        start_txn();
        send_read_hdr(addr);
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 24'(k);
            spi_byte(8'h00, rx);
            check_eq("read_byte", {24'd0, rx}, {24'd0, a[7:0]});
        end
        end_txn();
        check_eq("read_nfetch", rd_log.size(), nbytes + 1);
        for (int k = 0; k < rd_log.size() && k <= nbytes; k++) begin
            a = addr + 24'(k);
            check_eq("read_fetch_addr", {8'd0, rd_log[k]}, {8'd0, a});
        end
    endtask

    task automatic do_id(input int nbytes);
        logic [7:0]  rx;
        logic [31:0] exp_stream;
        exp_stream = {Jedec, 8'h00};
        start_txn();
        spi_byte(8'h9F, rx);
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(8'h00, rx);
            check_eq("id_byte", {24'd0, rx},
                     (k < 4) ? {24'd0, exp_stream[31-8*k -: 8]} : 32'd0);
        end
        end_txn();
        check_eq("id_no_fetch", rd_log.size(), 0);
    endtask

    initial begin
        logic [7:0]  rx;
        logic [23:0] ra;
        int          op;

        rst_n     = 1'b0;
        spi_cen   = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        wait_clk(3);
        check_eq("rst_miso", {31'd0, spi_miso}, 32'd1);
        check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // busy follows synchronized CEN
        spi_cen = 1'b0;
        wait_clk(4);
        check_eq("busy_low_cen", {31'd0, busy}, 32'd1);
        spi_cen = 1'b1;
        wait_clk(4);
        check_eq("busy_high_cen", {31'd0, busy}, 32'd0);

        do_read(24'h000010, 4, 2);
        do_id(4);
        do_read(24'hFFFFFE, 4, 1);

        // Unknown command: MISO held high, no fetches
        start_txn();
        spi_byte(8'h05, rx);
        spi_byte(8'hA5, rx);
        check_eq("ignore_miso0", {24'd0, rx}, 32'hFF);
        spi_byte(8'h5A, rx);
        check_eq("ignore_miso1", {24'd0, rx}, 32'hFF);
        end_txn();
        check_eq("ignore_no_fetch", rd_log.size(), 0);
        do_read(24'h000000, 2, 1);

        // Abort mid-byte: CEN rises after bit 4 of byte 2
        mem_lat = 1;
        start_txn();
        send_read_hdr(24'h000100);
        spi_byte(8'h00, rx);
        check_eq("abort_byte0", {24'd0, rx}, 32'h00);
        spi_bits(8'h00, 4, rx);
        spi_sclk = 1'b0;
        spi_cen  = 1'b1;
        wait_clk(3);
        check_eq("abort_miso", {31'd0, spi_miso}, 32'd1);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        wait_clk(8);
        do_read(24'h000020, 2, 2);
        check_eq("no_underrun_yet", {31'd0, underrun}, 32'd0);

        // Randomized mix of reads and ID transactions
        for (int t = 0; t < 8; t++) begin
            op = int'($urandom_range(0, 3));
            if (op == 3) begin
                do_id(int'($urandom_range(1, 5)));
            end else begin
                ra = 24'($urandom);
                if (op == 2) ra = 24'hFFFFFF - 24'($urandom_range(0, 3));
                do_read(ra, int'($urandom_range(1, 5)), int'($urandom_range(1, 2)));
            end
        end
        check_eq("rand_no_underrun", {31'd0, underrun}, 32'd0);

        // Memory late by 6 clk: first byte underruns, flag is sticky
        mem_lat = 6;
        start_txn();
        send_read_hdr(24'h000040);
        spi_byte(8'h00, rx);
        check_eq("underrun_byte", {24'd0, rx}, 32'hFF);
        check_eq("underrun_set", {31'd0, underrun}, 32'd1);
        end_txn();
        check_eq("underrun_sticky", {31'd0, underrun}, 32'd1);
        mem_lat = 1;
        wait_clk(10);

        // Asynchronous reset mid-transaction
        start_txn();
        send_read_hdr(24'h000080);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 3, rx);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_miso", {31'd0, spi_miso}, 32'd1);
        check_eq("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("arst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_underrun", {31'd0, underrun}, 32'd0);
        spi_cen  = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        do_read(24'h000033, 3, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
